// File: rtl/issue_ctrl_pkg.sv
// rtl/issue_ctrl_pkg.sv - shared widths, opcodes and state encodings for the issue stage
`ifndef ISSUE_CTRL_DEFINES
`define ISSUE_CTRL_DEFINES
`define instWidth 32
`define addrWidth 32
`define emptyInst 32'hFFFF_FFFF
`endif

package issue_ctrl_pkg;

    localparam int INST_WIDTH = `instWidth;
    localparam int ADDR_WIDTH = `addrWidth;

    // PC presented when there is no valid head, so the decoder emits emptyOp
    localparam logic [ADDR_WIDTH-1:0] EMPTY_INST = `emptyInst;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    typedef enum logic [1:0] {
        IC_RUN   = 2'd0,
        IC_HOLD  = 2'd1,
        IC_FLUSH = 2'd2
    } ic_state_e;

    function automatic logic is_load_store(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/issue_ctrl_fifo.sv
// rtl/issue_ctrl_fifo.sv - instruction/PC FIFO with wrap-around pointers and a full/empty count
module inst_fifo
    import issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  push_in,
    input  logic                  pop_in,
    input  logic                  clear_in,
    input  logic [INST_WIDTH-1:0] inst_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic [INST_WIDTH-1:0] head_inst_out,
    output logic [ADDR_WIDTH-1:0] head_pc_out,
    output logic                  full_out,
    output logic                  empty_out
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [INST_WIDTH-1:0] inst_q [DEPTH];
    logic [INST_WIDTH-1:0] inst_d [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_d   [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  push_ok, pop_ok;

    // Full is taken from the registered count only, so a same-cycle pop never frees a slot
    assign full_out  = (count_q == FULL_CNT);
    assign empty_out = (count_q == '0);
    assign push_ok   = push_in && !full_out;
    assign pop_ok    = pop_in && !empty_out;

    assign head_inst_out = inst_q[head_q];
    assign head_pc_out   = pc_q[head_q];

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                inst_d[tail_q] = inst_in;
                pc_d[tail_q]   = pc_in;
                tail_d         = tail_q + PTR_W'(1);
            end
            if (pop_ok) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - presents the buffered fetch head to the decoder and sequences JALR hold and rollback flush
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  push_in,
    input  logic [INST_WIDTH-1:0] inst_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  queue_full_out,
    output logic [INST_WIDTH-1:0] inst_to_dec,
    output logic [ADDR_WIDTH-1:0] pc_to_dec,
    output logic                  if_ls_to_dec,
    input  logic                  station_idle_in,
    output logic                  issued_out,
    output logic                  hold_out,
    input  logic                  redirect_in,
    input  logic                  rollback_in
);

    ic_state_e             state_q, state_d;
    logic                  hold_q;
    logic                  fifo_full, fifo_empty;
    logic [INST_WIDTH-1:0] head_inst;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic                  head_valid, head_is_jalr;
    logic                  push_req, clear_req;

    assign head_valid   = !fifo_empty && (state_q == IC_RUN) && !rollback_in;
    assign issued_out   = rdy_in && head_valid && station_idle_in;
    assign head_is_jalr = (head_inst[6:0] == OPC_JALR);

    // Rollback discards the same-cycle push; FLUSH drops pushes because the clear wins anyway
    assign push_req  = rdy_in && push_in && !rollback_in && (state_q != IC_FLUSH);
    assign clear_req = rdy_in && (rollback_in || (state_q == IC_FLUSH));

    inst_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .push_in       (push_req),
        .pop_in        (issued_out),
        .clear_in      (clear_req),
        .inst_in       (inst_in),
        .pc_in         (pc_in),
        .head_inst_out (head_inst),
        .head_pc_out   (head_pc),
        .full_out      (fifo_full),
        .empty_out     (fifo_empty)
    );

    assign queue_full_out = fifo_full;
    assign inst_to_dec    = head_valid ? head_inst : '0;
    assign pc_to_dec      = head_valid ? head_pc : EMPTY_INST;
    assign if_ls_to_dec   = head_valid && is_load_store(head_inst[6:0]);
    assign hold_out       = hold_q;

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            if (rollback_in) begin
                state_d = IC_RUN;
            end else begin
                case (state_q)
                    IC_RUN:   if (issued_out && head_is_jalr) state_d = IC_HOLD;
                    IC_HOLD:  if (redirect_in) state_d = IC_FLUSH;
                    IC_FLUSH: state_d = IC_RUN;
                    default:  state_d = IC_RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IC_RUN;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= (state_d != IC_RUN);
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed and random stimulus against a queue-based reference of the issue stage
module tb_issue_ctrl;

    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDI  = 32'h0010_0093;
    localparam logic [31:0] SW    = 32'h0011_2023;
    localparam logic [31:0] JALR  = 32'h0000_80E7;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, push_in, station_idle_in, redirect_in, rollback_in;
    logic [31:0] inst_in, pc_in;
    logic        queue_full_out, if_ls_to_dec, issued_out, hold_out;
    logic [31:0] inst_to_dec, pc_to_dec;

    ent_t q[$];
    bit   holding  = 1'b0;
    bit   flushing = 1'b0;
    bit   known    = 1'b0;
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk_in = ~clk_in;

    issue_ctrl dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .push_in         (push_in),
        .inst_in         (inst_in),
        .pc_in           (pc_in),
        .queue_full_out  (queue_full_out),
        .inst_to_dec     (inst_to_dec),
        .pc_to_dec       (pc_to_dec),
        .if_ls_to_dec    (if_ls_to_dec),
        .station_idle_in (station_idle_in),
        .issued_out      (issued_out),
        .hold_out        (hold_out),
        .redirect_in     (redirect_in),
        .rollback_in     (rollback_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit opc_is_ls(input logic [31:0] inst);
        return (inst[6:0] == 7'b0000011) || (inst[6:0] == 7'b0100011);
    endfunction

    // One clock: drive inputs, check outputs against the reference at negedge, advance the reference at posedge
    task automatic step(input logic rst, input logic rdy, input logic push,
                        input logic [31:0] inst, input logic [31:0] pc,
                        input logic idle, input logic redir, input logic rb);
        logic        valid, e_iss, e_ls, e_full, e_hold, was_full;
        logic [31:0] e_pc, e_inst;
        ent_t        e;
        rst_in = rst; rdy_in = rdy; push_in = push; inst_in = inst; pc_in = pc;
        station_idle_in = idle; redirect_in = redir; rollback_in = rb;

        valid  = (q.size() != 0) && !holding && !flushing && !rb;
        e_pc   = EMPTY;
        e_inst = '0;
        e_ls   = 1'b0;
        if (valid) begin
            e_pc   = q[0].pc;
            e_inst = q[0].inst;
            e_ls   = opc_is_ls(q[0].inst);
        end
        e_iss  = rdy && valid && idle;
        e_full = (q.size() == 4);
        e_hold = holding || flushing;

        @(negedge clk_in);
        if (known) begin
            chk("issued",  32'(issued_out),     32'(e_iss));
            chk("pc",      pc_to_dec,           e_pc);
            chk("inst",    inst_to_dec,         e_inst);
            chk("if_ls",   32'(if_ls_to_dec),   32'(e_ls));
            chk("full",    32'(queue_full_out), 32'(e_full));
            chk("hold",    32'(hold_out),       32'(e_hold));
        end

        @(posedge clk_in);
        if (rst) begin
            q.delete();
            holding  = 1'b0;
            flushing = 1'b0;
            known    = 1'b1;
        end else if (rdy) begin
            if (rb) begin
                q.delete();
                holding  = 1'b0;
                flushing = 1'b0;
            end else if (flushing) begin
                q.delete();
                flushing = 1'b0;
            end else begin
                was_full = (q.size() == 4);
                if (holding) begin
                    if (redir) begin
                        holding  = 1'b0;
                        flushing = 1'b1;
                    end
                end else if (e_iss) begin
                    if (q[0].inst[6:0] == 7'b1100111) holding = 1'b1;
                    void'(q.pop_front());
                end
                if (push) begin
                    if (was_full) begin
                        $display("note: fetcher pushed pc %h while queue full; dropped", pc);
                    end else begin
                        e.inst = inst;
                        e.pc   = pc;
                        q.push_back(e);
                    end
                end
            end
        end
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  opc;
        r = $urandom();
        case ($urandom_range(0, 4))
            0:       opc = 7'b0010011;
            1:       opc = 7'b0000011;
            2:       opc = 7'b0100011;
            3:       opc = 7'b1100111;
            default: opc = 7'b0110011;
        endcase
        return {r[31:7], opc};
    endfunction

    initial begin
        logic [31:0] pcn;
        rst_in = 1'b1; rdy_in = 1'b0; push_in = 1'b0; inst_in = '0; pc_in = '0;
        station_idle_in = 1'b0; redirect_in = 1'b0; rollback_in = 1'b0;
        #1;

        // reset held two cycles while pushing
        step(1'b1, 1'b1, 1'b1, ADDI, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, ADDI, 32'h0, 1'b0, 1'b0, 1'b0);

        // basic issue: ADDI then SW
        step(1'b0, 1'b1, 1'b1, ADDI, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, SW,   32'h4, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0,   '0,    1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0,   '0,    1'b1, 1'b0, 1'b0);

        // fill past full with the decoder stalled, drain, then wrap the pointers
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, ADDI, 32'(i*4), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, SW, 32'h40 + 32'(i*4), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // JALR with two entries behind it, hold, redirect, flush
        step(1'b0, 1'b1, 1'b1, JALR, 32'h100, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, ADDI, 32'h104, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, ADDI, 32'h108, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, SW, 32'h10c, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, ADDI, 32'h200, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // rollback with three queued, push and idle asserted together
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, ADDI, 32'h300 + 32'(i*4), 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, ADDI, 32'h30c, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // rdy_in low with two queued and the decoder idle
        step(1'b0, 1'b1, 1'b1, SW,   32'h400, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, ADDI, 32'h404, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, JALR, 32'h408, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // random traffic
        pcn = 32'h1000;
        for (int i = 0; i < 500; i++) begin
            logic r_rst, r_rdy, r_push, r_idle, r_redir, r_rb;
            r_rst   = ($urandom_range(0, 99) == 0);
            r_rdy   = ($urandom_range(0, 7) != 0);
            r_push  = ($urandom_range(0, 2) != 0) && (q.size() < 4 || $urandom_range(0, 9) == 0);
            r_idle  = $urandom_range(0, 1) == 1;
            r_redir = ($urandom_range(0, 5) == 0);
            r_rb    = ($urandom_range(0, 19) == 0);
            step(r_rst, r_rdy, r_push, rand_inst(), pcn, r_idle, r_redir, r_rb);
            if (r_push) pcn = pcn + 32'd4;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
